// File: rtl/btn_rgb_timer_pkg.sv
// ---------------------------------------------------------------------------
// btn_rgb_pkg
// Shared types and constants for the multi-button RGB LED timer.
//   state_t   : top-level FSM states (IDLE, SHOW)
//   C_*       : 3-bit {r,g,b} colour constants
//   MAX_BTN   : largest supported button count
//   color_of  : picks the {r,g,b} slice for one button out of a packed table
// ---------------------------------------------------------------------------
package btn_rgb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SHOW = 1'b1
    } state_t;

    localparam logic [2:0] C_OFF     = 3'b000;
    localparam logic [2:0] C_RED     = 3'b100;
    localparam logic [2:0] C_GREEN   = 3'b010;
    localparam logic [2:0] C_BLUE    = 3'b001;
    localparam logic [2:0] C_CYAN    = 3'b011;
    localparam logic [2:0] C_YELLOW  = 3'b110;
    localparam logic [2:0] C_MAGENTA = 3'b101;
    localparam logic [2:0] C_WHITE   = 3'b111;

    localparam int MAX_BTN = 8;

    // Table is zero-extended to the maximum size so one function serves
    // every NUM_BTN; slice [3i+2:3i] belongs to button i.
    function automatic logic [2:0] color_of(input logic [3*MAX_BTN-1:0] tbl,
                                            input int unsigned          idx);
        return tbl[3*idx +: 3];
    endfunction

endpackage

// File: rtl/btn_rgb_timer_if.sv
// ---------------------------------------------------------------------------
// btn_rgb_timer_if
// Board-side signal bundle of the RGB LED timer.
//   btn        : raw asynchronous push-buttons, active-high (NUM_BTN bits)
//   led_r/g/b  : registered LED drives
//   busy       : high while a button colour is being shown
//   active_idx : index of the button being shown (holds when idle)
// Modports: master = board/stimulus side, slave = timer side.
// ---------------------------------------------------------------------------
interface btn_rgb_timer_if #(
    parameter int NUM_BTN = 2
);
    localparam int IDX_W = (NUM_BTN > 1) ? $clog2(NUM_BTN) : 1;

    logic [NUM_BTN-1:0] btn;
    logic               led_r;
    logic               led_g;
    logic               led_b;
    logic               busy;
    logic [IDX_W-1:0]   active_idx;

    modport master (
        output btn,
        input  led_r, led_g, led_b, busy, active_idx
    );

    modport slave (
        input  btn,
        output led_r, led_g, led_b, busy, active_idx
    );

endinterface

// File: rtl/btn_rgb_timer_debounce.sv
// ---------------------------------------------------------------------------
// btn_debounce
// One button's input path: 2-flop synchroniser, debounce counter and a
// registered one-cycle press pulse on the debounced rising edge.
//   clk, rst_n : clock, asynchronous active-low reset
//   btn_raw    : raw asynchronous button level
//   press      : one-cycle pulse per qualified press
// A press is only reported once the button has been seen released since
// reset, so a button held through reset never produces a press.
// ---------------------------------------------------------------------------
module btn_debounce #(
    parameter int DB_CYCLES = 65536
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic press
);
    localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

    logic             sync1_reg;
    logic             sync2_reg;
    logic [1:0]       vld_reg;
    logic             level_reg;
    logic             level_dly_reg;
    logic             armed_reg;
    logic             press_reg;
    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg     <= 1'b0;
            sync2_reg     <= 1'b0;
            vld_reg       <= 2'b00;
            level_reg     <= 1'b0;
            level_dly_reg <= 1'b0;
            armed_reg     <= 1'b0;
            press_reg     <= 1'b0;
            cnt_reg       <= '0;
        end else begin
            sync1_reg <= btn_raw;
            sync2_reg <= sync1_reg;
            // Marks when sync2 holds a real sample rather than its reset zero.
            vld_reg   <= {vld_reg[0], 1'b1};

            if (sync2_reg == level_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CNT_W'(DB_CYCLES - 1)) begin
                level_reg <= ~level_reg;
                cnt_reg   <= '0;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end

            // Arm once a genuine released sample is seen; stays armed until reset.
            if (vld_reg[1] && !sync2_reg && !level_reg) begin
                armed_reg <= 1'b1;
            end

            level_dly_reg <= level_reg;
            press_reg     <= level_reg & ~level_dly_reg & armed_reg;
        end
    end

    assign press = press_reg;

endmodule

// File: rtl/btn_rgb_timer.sv
// ---------------------------------------------------------------------------
// btn_rgb_timer
// Multi-button RGB LED timer. A press on button i shows COLOR_TABLE slice i
// for HOLD_CYCLES clocks, then the LEDs fall back to IDLE_COLOR. Lowest
// index wins on simultaneous presses; a press during SHOW retriggers.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   io    : btn_rgb_timer_if.slave (btn in; led_r/g/b, busy, active_idx out)
// Optional build macro BTN_RGB_BLINK_EN: blink the colour during the final
// quarter of the hold, toggled by bit BLINK_SHIFT of a counter that clears
// on every SHOW entry. Without it the colour is steady.
// ---------------------------------------------------------------------------
import btn_rgb_pkg::*;

module btn_rgb_timer #(
    parameter int                   NUM_BTN     = 2,
    parameter int                   HOLD_CYCLES = 67108864,
    parameter int                   DB_CYCLES   = 65536,
    parameter logic [3*NUM_BTN-1:0] COLOR_TABLE = {3'b110, 3'b011},
    parameter logic [2:0]           IDLE_COLOR  = 3'b001,
    parameter int                   BLINK_SHIFT = 22
) (
    input  logic            clk,
    input  logic            rst_n,
    btn_rgb_timer_if.slave  io
);
    localparam int IDX_W = (NUM_BTN > 1) ? $clog2(NUM_BTN) : 1;
    localparam int CNT_W = $clog2(HOLD_CYCLES);
    localparam logic [3*MAX_BTN-1:0] TABLE_EXT = (3*MAX_BTN)'(COLOR_TABLE);

    logic [NUM_BTN-1:0] press_vec;
    logic [IDX_W-1:0]   sel_idx;
    logic               any_press;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [IDX_W-1:0]   idx_reg, idx_next;
    logic [2:0]         led_reg, led_next;
    logic               busy_reg, busy_next;
`ifdef BTN_RGB_BLINK_EN
    logic [BLINK_SHIFT:0] blink_reg, blink_next;
`endif

    generate
        for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
            btn_debounce #(
                .DB_CYCLES (DB_CYCLES)
            ) u_debounce (
                .clk     (clk),
                .rst_n   (rst_n),
                .btn_raw (io.btn[gi]),
                .press   (press_vec[gi])
            );
        end
    endgenerate

    // Scan from the top down so the lowest pressed index is left standing.
    always_comb begin
        sel_idx = '0;
        for (int i = NUM_BTN - 1; i >= 0; i--) begin
            if (press_vec[i]) begin
                sel_idx = IDX_W'(i);
            end
        end
    end

    assign any_press = |press_vec;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        idx_next   = idx_reg;
        led_next   = IDLE_COLOR;
        busy_next  = 1'b0;

        case (state_reg)
            IDLE: begin
                if (any_press) begin
                    state_next = SHOW;
                    cnt_next   = '0;
                    idx_next   = sel_idx;
                end
            end
            SHOW: begin
                // A press coinciding with expiry still wins and restarts the hold.
                if (any_press) begin
                    cnt_next = '0;
                    idx_next = sel_idx;
                end else if (cnt_reg == CNT_W'(HOLD_CYCLES - 1)) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase

`ifdef BTN_RGB_BLINK_EN
        blink_next = any_press ? '0 : blink_reg + 1'b1;
`endif

        // Outputs are computed from next-state values so the registered
        // LEDs change on the same edge as the FSM.
        if (state_next == SHOW) begin
            led_next  = color_of(TABLE_EXT, 32'(idx_next));
            busy_next = 1'b1;
`ifdef BTN_RGB_BLINK_EN
            if (cnt_next >= CNT_W'(HOLD_CYCLES - HOLD_CYCLES / 4) && blink_next[BLINK_SHIFT]) begin
                led_next = C_OFF;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            idx_reg   <= '0;
            led_reg   <= IDLE_COLOR;
            busy_reg  <= 1'b0;
`ifdef BTN_RGB_BLINK_EN
            blink_reg <= '0;
`endif
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            idx_reg   <= idx_next;
            led_reg   <= led_next;
            busy_reg  <= busy_next;
`ifdef BTN_RGB_BLINK_EN
            blink_reg <= blink_next;
`endif
        end
    end

    assign io.led_r      = led_reg[2];
    assign io.led_g      = led_reg[1];
    assign io.led_b      = led_reg[0];
    assign io.busy       = busy_reg;
    assign io.active_idx = idx_reg;

endmodule

// File: tb/tb_btn_rgb_timer.sv
// ---------------------------------------------------------------------------
// tb_btn_rgb_timer
// Self-checking bench for btn_rgb_timer (NUM_BTN=4, HOLD_CYCLES=10,
// DB_CYCLES=4, IDLE_COLOR=001, BLINK_SHIFT=0). Directed scenario tasks
// followed by a randomized run checked against a behavioural model.
// Honours BTN_RGB_BLINK_EN when defined.
// ---------------------------------------------------------------------------
module tb_btn_rgb_timer;
    import btn_rgb_pkg::*;

    localparam int         NB       = 4;
    localparam int         HOLD     = 10;
    localparam int         DB       = 4;
    localparam logic [11:0] TB_TABLE = {3'b100, 3'b010, 3'b110, 3'b011};
    localparam logic [2:0] IDLE_C   = 3'b001;
    localparam int         BSHIFT   = 0;

    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    btn_rgb_timer_if #(.NUM_BTN(NB)) bus ();

    btn_rgb_timer #(
        .NUM_BTN     (NB),
        .HOLD_CYCLES (HOLD),
        .DB_CYCLES   (DB),
        .COLOR_TABLE (TB_TABLE),
        .IDLE_COLOR  (IDLE_C),
        .BLINK_SHIFT (BSHIFT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    function automatic logic [2:0] leds();
        return {bus.led_r, bus.led_g, bus.led_b};
    endfunction

    function automatic logic [2:0] exp_color(input int i);
        logic [11:0] t;
        t = TB_TABLE;
        return t[3*i +: 3];
    endfunction

    // LED value expected at show cycle c (0-based) for button i.
    function automatic logic [2:0] exp_show(input int i, input int c);
`ifdef BTN_RGB_BLINK_EN
        if (c >= HOLD - HOLD / 4 && (((c >> BSHIFT) & 1) == 1)) return 3'b000;
`endif
        return exp_color(i);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [NB-1:0] b);
        bus.btn = b;
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_busy(input int limit, output int n);
        n = 0;
        while (!bus.busy && n < limit) begin
            tick();
            n++;
        end
    endtask

    task automatic settle(input string name);
        int n;
        n = 0;
        while (bus.busy && n < 60) begin
            tick();
            n++;
        end
        total++;
        if (bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL %s_idle: busy=%0b want 0", name, bus.busy);
        end
        bus.btn = '0;
        repeat (15) tick();
    endtask

    // ---------------- behavioural model ----------------
    logic [NB-1:0] raw_q[$];
    logic [NB-1:0] rise_q[$];
    int            run_m[NB];
    logic [NB-1:0] db_m;
    logic [NB-1:0] armed_m;
    int            left_m;
    int            idx_m;
    int            edge_m;

    task automatic model_reset();
        raw_q.delete();  raw_q.push_back('0);  raw_q.push_back('0);
        rise_q.delete(); rise_q.push_back('0); rise_q.push_back('0);
        for (int b = 0; b < NB; b++) run_m[b] = 0;
        db_m = '0; armed_m = '0; left_m = 0; idx_m = 0; edge_m = 0;
    endtask

    // One clock edge: raw is the button vector present at that edge.
    task automatic model_step(input logic [NB-1:0] raw);
        logic [NB-1:0] seen, p, rise_now;
        edge_m++;
        seen = raw_q.pop_front();   // input as seen two clocks later
        raw_q.push_back(raw);
        p = rise_q.pop_front();     // press reaching the timer this edge
        rise_now = '0;
        for (int b = 0; b < NB; b++) begin
            if (edge_m >= 3 && !seen[b] && !db_m[b]) armed_m[b] = 1'b1;
            if (seen[b] != db_m[b]) begin
                run_m[b]++;
                if (run_m[b] == DB) begin
                    run_m[b] = 0;
                    db_m[b] = ~db_m[b];
                    if (db_m[b] && armed_m[b]) rise_now[b] = 1'b1;
                end
            end else begin
                run_m[b] = 0;
            end
        end
        rise_q.push_back(rise_now);
        if (p != '0) begin
            for (int b = NB - 1; b >= 0; b--) if (p[b]) idx_m = b;
            left_m = HOLD;
        end else if (left_m > 0) begin
            left_m--;
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        int n, seen_busy;
        do_reset(4'b0010);
        total++; if (leds() !== IDLE_C) begin bad++; $display("FAIL reset_led: got %b want %b", leds(), IDLE_C); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        total++; if (bus.active_idx !== 2'd0) begin bad++; $display("FAIL reset_idx: got %0d want 0", bus.active_idx); end
        seen_busy = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (bus.busy || leds() !== IDLE_C) seen_busy++;
        end
        total++; if (seen_busy != 0) begin bad++; $display("FAIL held_through_reset: active cycles=%0d want 0", seen_busy); end
        bus.btn[1] = 1'b0;
        repeat (12) tick();
        bus.btn[1] = 1'b1;
        wait_busy(20, n);
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL repress_busy: got %b want 1", bus.busy); end
        total++; if (bus.active_idx !== 2'd1) begin bad++; $display("FAIL repress_idx: got %0d want 1", bus.active_idx); end
        total++; if (leds() !== exp_color(1)) begin bad++; $display("FAIL repress_led: got %b want %b", leds(), exp_color(1)); end
        settle("reset");
    endtask

    task automatic test_clean_press();
        int n, len;
        bus.btn[0] = 1'b1;
        wait_busy(20, n);
        total++; if (n != 8) begin bad++; $display("FAIL press_latency: got %0d want 8", n); end
        total++; if (leds() !== exp_color(0)) begin bad++; $display("FAIL press_led: got %b want %b", leds(), exp_color(0)); end
        len = (bus.busy === 1'b1) ? 1 : 0;
        while (bus.busy && len < 40) begin
            tick();
            if (bus.busy) len++;
        end
        total++; if (len != HOLD) begin bad++; $display("FAIL hold_length: got %0d want %0d", len, HOLD); end
        total++; if (leds() !== IDLE_C) begin bad++; $display("FAIL expire_led: got %b want %b", leds(), IDLE_C); end
        settle("clean");
    endtask

    task automatic test_bounce();
        int n, early, shows;
        early = 0;
        for (int c = 0; c < 20; c++) begin
            bus.btn[2] = ((c / 3) % 2) == 0;
            tick();
            if (bus.busy) early++;
        end
        bus.btn[2] = 1'b1;
        total++; if (early != 0) begin bad++; $display("FAIL bounce_quiet: busy cycles=%0d want 0", early); end
        wait_busy(20, n);
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL bounce_show: busy=%b want 1", bus.busy); end
        total++; if (leds() !== exp_color(2)) begin bad++; $display("FAIL bounce_led: got %b want %b", leds(), exp_color(2)); end
        shows = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (bus.busy && c > HOLD) shows++;
        end
        total++; if (shows != 0) begin bad++; $display("FAIL bounce_single: extra busy=%0d want 0", shows); end
        settle("bounce");
    endtask

    task automatic test_simultaneous();
        int n, saw3;
        bus.btn = 4'b1010;
        wait_busy(20, n);
        total++; if (bus.active_idx !== 2'd1) begin bad++; $display("FAIL simul_idx: got %0d want 1", bus.active_idx); end
        total++; if (leds() !== exp_color(1)) begin bad++; $display("FAIL simul_led: got %b want %b", leds(), exp_color(1)); end
        saw3 = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (bus.active_idx == 2'd3 || bus.busy && c >= HOLD) saw3++;
        end
        total++; if (saw3 != 0) begin bad++; $display("FAIL simul_discard: btn3 activity=%0d want 0", saw3); end
        settle("simul");
    endtask

    task automatic test_retrigger();
        int start, len;
        start = -1; len = 0;
        bus.btn[3] = 1'b1;
        for (int t = 1; t <= 60; t++) begin
            if (t == 11) bus.btn[0] = 1'b1;
            tick();
            if (bus.busy) begin
                if (start < 0) start = t;
                len++;
            end
            if (start > 0 && t == start + 9) begin
                total++; if (leds() !== exp_show(3, 9)) begin bad++; $display("FAIL retrig_last: got %b want %b", leds(), exp_show(3, 9)); end
            end
            if (start > 0 && t == start + 10) begin
                total++; if (leds() !== exp_color(0) || bus.active_idx !== 2'd0) begin
                    bad++; $display("FAIL retrig_new: led=%b idx=%0d want %b idx 0", leds(), bus.active_idx, exp_color(0));
                end
            end
        end
        total++; if (start != 8) begin bad++; $display("FAIL retrig_start: got %0d want 8", start); end
        total++; if (len != 2 * HOLD) begin bad++; $display("FAIL retrig_total: got %0d want %0d", len, 2 * HOLD); end
        settle("retrig");
    endtask

    task automatic test_async_reset();
        int n, after;
        bus.btn[2] = 1'b1;
        wait_busy(20, n);
        repeat (5) tick();
        #3;
        rst_n = 1'b0;
        #1;
        total++; if (leds() !== IDLE_C) begin bad++; $display("FAIL arst_led: got %b want %b", leds(), IDLE_C); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL arst_busy: got %b want 0", bus.busy); end
        total++; if (bus.active_idx !== 2'd0) begin bad++; $display("FAIL arst_idx: got %0d want 0", bus.active_idx); end
        repeat (2) tick();
        rst_n = 1'b1;
        after = 0;
        for (int c = 0; c < 25; c++) begin
            tick();
            if (bus.busy) after++;
        end
        total++; if (after != 0) begin bad++; $display("FAIL arst_nopress: busy cycles=%0d want 0", after); end
        settle("arst");
    endtask

`ifdef BTN_RGB_BLINK_EN
    task automatic test_blink();
        int n;
        bus.btn[0] = 1'b1;
        wait_busy(20, n);
        for (int c = 0; c < HOLD; c++) begin
            total++; if (leds() !== exp_show(0, c)) begin bad++; $display("FAIL blink_c%0d: got %b want %b", c, leds(), exp_show(0, c)); end
            tick();
        end
        settle("blink");
    endtask
`endif

    task automatic test_random();
        int            hold_left[NB];
        logic [NB-1:0] cur;
        logic [2:0]    exp_led;
        cur = '0;
        for (int b = 0; b < NB; b++) hold_left[b] = 0;
        do_reset('0);
        model_reset();
        for (int cyc = 0; cyc < 900; cyc++) begin
            for (int b = 0; b < NB; b++) begin
                if (hold_left[b] == 0) begin
                    cur[b] = ($urandom_range(0, 3) == 0);
                    hold_left[b] = $urandom_range(1, 14);
                end
                hold_left[b]--;
            end
            bus.btn = cur;
            tick();
            model_step(cur);
            exp_led = (left_m > 0) ? exp_show(idx_m, HOLD - left_m) : IDLE_C;
            total++; if (leds() !== exp_led) begin bad++; $display("FAIL rand_led@%0d: got %b want %b", cyc, leds(), exp_led); end
            total++; if (bus.busy !== (left_m > 0)) begin bad++; $display("FAIL rand_busy@%0d: got %b want %b", cyc, bus.busy, left_m > 0); end
            total++; if (bus.active_idx !== 2'(idx_m)) begin bad++; $display("FAIL rand_idx@%0d: got %0d want %0d", cyc, bus.active_idx, idx_m); end
        end
        settle("rand");
    endtask

    initial begin
        rst_n   = 1'b0;
        bus.btn = '0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_simultaneous();
        test_retrigger();
        test_async_reset();
`ifdef BTN_RGB_BLINK_EN
        test_blink();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
